uart_echo_fifo: RTL and testbench

//  Parametrised 8N1 UART core: oversampled receiver, transmitter, RX and TX FIFOs.

---
 rtl/uart_echo_fifo.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// 8N1 UART core: oversampled receiver, transmitter, RX/TX byte FIFOs and an
// optional hardware echo of received bytes whose code lies in [ECHO_LO, ECHO_HI].

module uart_echo_fifo_buf #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // a push into a full FIFO is dropped even when a pop frees a slot that cycle
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// state    | meaning
// RX_IDLE  | line idle, looking for a low sample at a tick
// RX_START | timing to the middle of the start bit
// RX_DATA  | sampling 8 data bits LSB-first, one per bit period
// RX_STOP  | timing to the middle of the stop bit
// RX_WAIT  | framing error seen, waiting for the line to return high
// TX_IDLE  | nothing to send, pops the FIFO head when one is present
// TX_LOAD  | byte loaded, waiting for the next tick to begin the start bit
// TX_START | driving the start bit
// TX_DATA  | driving 8 data bits LSB-first
// TX_STOP  | driving the stop bit
module uart_echo_fifo #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         BAUD       = 9600,
  parameter int         OVERSAMPLE = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter bit         ECHO_EN    = 1'b1,
  parameter logic [7:0] ECHO_LO    = 8'h21,
  parameter logic [7:0] ECHO_HI    = 8'h7A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  output logic       RsTx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       frame_err,
  output logic       rx_overrun,
  output logic       echo_drop,
  input  logic       err_clr
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_TC = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    rx_sync;
  logic          rx_s;

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_push, rx_push_n, frame_err_n;

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_line, tx_line_n, tx_pop;

  logic          rx_empty, rx_full, tx_empty, tx_full;
  logic          echo_push, tx_push;
  logic [7:0]    tx_din, tx_head;

  assign tick = (div_cnt == DW'(DIV - 1));
  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      rx_sync <= 2'b11;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      rx_sync <= {rx_sync[0], RsRx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_push   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_sh     <= rx_sh_n;
      rx_push   <= rx_push_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_push_n   = 1'b0;
    frame_err_n = 1'b0;
    case (rx_state)
      RX_IDLE: if (tick && !rx_s) begin
        rx_state_n = RX_START;
        rx_cnt_n   = HALF_TC;
      end
      RX_START: if (tick) begin
        if (rx_cnt != '0) rx_cnt_n = rx_cnt - 1'b1;
        else if (rx_s)    rx_state_n = RX_IDLE;
        else begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = BIT_TC;
          rx_bit_n   = '0;
        end
      end
      RX_DATA: if (tick) begin
        if (rx_cnt != '0) rx_cnt_n = rx_cnt - 1'b1;
        else begin
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          rx_cnt_n = BIT_TC;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 1'b1;
        end
      end
      RX_STOP: if (tick) begin
        if (rx_cnt != '0) rx_cnt_n = rx_cnt - 1'b1;
        else if (rx_s) begin
          rx_push_n  = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          frame_err_n = 1'b1;
          rx_state_n  = RX_WAIT;
        end
      end
      RX_WAIT: if (rx_s) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // echo shares the RX push cycle and pre-empts the host on the TX FIFO
  assign echo_push = ECHO_EN && rx_push && (rx_sh >= ECHO_LO) && (rx_sh <= ECHO_HI);
  assign tx_ready  = rst_n & ~tx_full & ~echo_push;
  assign tx_push   = echo_push | (tx_valid & tx_ready);
  assign tx_din    = echo_push ? rx_sh : tx_data;
  assign rx_valid  = ~rx_empty;

  uart_echo_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_sh), .pop(rx_ready),
    .dout(rx_data), .empty(rx_empty), .full(rx_full)
  );

  uart_echo_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(tx_din), .pop(tx_pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
      echo_drop  <= 1'b0;
    end else begin
      if (rx_push && rx_full) rx_overrun <= 1'b1;
      else if (err_clr)       rx_overrun <= 1'b0;
      if (echo_push && tx_full) echo_drop <= 1'b1;
      else if (err_clr)         echo_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_n    = tx_head;
        tx_state_n = TX_LOAD;
      end
      TX_LOAD: if (tick) begin
        tx_line_n  = 1'b0;
        tx_cnt_n   = BIT_TC;
        tx_state_n = TX_START;
      end
      TX_START: if (tick) begin
        if (tx_cnt != '0) tx_cnt_n = tx_cnt - 1'b1;
        else begin
          tx_line_n  = tx_sh[0];
          tx_cnt_n   = BIT_TC;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: if (tick) begin
        if (tx_cnt != '0) tx_cnt_n = tx_cnt - 1'b1;
        else begin
          tx_cnt_n = BIT_TC;
          if (tx_bit == 3'd7) begin
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            tx_sh_n   = {1'b0, tx_sh[7:1]};
            tx_line_n = tx_sh[1];
            tx_bit_n  = tx_bit + 1'b1;
          end
        end
      end
      TX_STOP: if (tick) begin
        if (tx_cnt != '0) tx_cnt_n = tx_cnt - 1'b1;
        else              tx_state_n = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign RsTx = tx_line;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench: bytes expected on the RX stream and on RsTx are queued when
// stimulus is issued; independent monitors pop and compare as the DUT delivers them.
module tb_uart_echo_fifo;
  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int DEPTH    = 16;
  localparam int DIV      = CLK_HZ / (BAUD * OS);
  localparam int BIT_CLKS = DIV * OS;
  localparam logic [7:0] LO = 8'h21;
  localparam logic [7:0] HI = 8'h7A;

  logic       clk = 1'b0, rst_n = 1'b0, RsRx = 1'b1, rx_ready = 1'b0;
  logic       tx_valid = 1'b0, err_clr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       RsTx, rx_valid, tx_ready, frame_err, rx_overrun, echo_drop;
  logic [7:0] rx_data;

  int errors = 0, checks = 0, cyc = 0, fe_cnt = 0;
  int frame_start = 0;
  bit mon_en = 1'b0, rx_hold = 1'b1, check_gap = 1'b0, exp_ovr = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  uart_echo_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH),
    .ECHO_EN(1'b1), .ECHO_LO(LO), .ECHO_HI(HI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .RsRx(RsRx), .RsTx(RsTx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_err(frame_err), .rx_overrun(rx_overrun), .echo_drop(echo_drop),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 rx_ready = rx_hold ? 1'b0 : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else check("rx_data", rx_data, exp_rx.pop_front());
    end
  end

  // serial decoder for RsTx, sampling each bit at its middle
  initial begin
    logic [7:0] b;
    int gap;
    forever begin
      @(negedge clk);
      if (mon_en && RsTx == 1'b0) begin
        repeat (BIT_CLKS/2) @(negedge clk);
        check("tx_start_bit", RsTx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          b[i] = RsTx;
        end
        repeat (BIT_CLKS) @(negedge clk);
        check("tx_stop_bit", RsTx, 1);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %0h expected none", b);
        end else check("tx_byte", b, exp_tx.pop_front());
        if (check_gap && exp_tx.size() != 0) begin
          gap = 0;
          while (RsTx && gap < BIT_CLKS) begin @(negedge clk); gap++; end
          check("tx_no_gap", gap <= BIT_CLKS/2 + 2*DIV, 1);
        end
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got %0d cycles expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic model_good(input logic [7:0] b);
    if (exp_rx.size() < DEPTH) exp_rx.push_back(b);
    else exp_ovr = 1'b1;
    if (b >= LO && b <= HI) exp_tx.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    RsRx = 1'b0;
    frame_start = cyc;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    RsRx = stop;
    if (stop) model_good(b);
    repeat (BIT_CLKS) @(negedge clk);
    RsRx = 1'b1;
    if (!stop) repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic host_send(input logic [7:0] b);
    int n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    #1;
    while (!tx_ready && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (tx_ready) begin
      exp_tx.push_back(b);
      @(negedge clk);
    end else begin
      errors++;
      $display("FAIL host_send_timeout: got tx_ready=0 expected 1");
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_rx.size() != 0 || exp_tx.size() != 0) && n < 15000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 15000) begin
      errors++;
      $display("FAIL drain_timeout: got rx=%0d tx=%0d pending expected 0", exp_rx.size(), exp_tx.size());
    end
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    int n, fe0, s0, p, tgt;
    logic [7:0] b;

    repeat (5) @(negedge clk);
    check("reset_rstx", RsTx, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_rx_overrun", rx_overrun, 0);
    check("reset_echo_drop", echo_drop, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // host byte started, then reset in the middle of its start bit
    tx_data = 8'hA5; tx_valid = 1'b1; #1;
    check("tx_ready_idle", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (RsTx && n < 100) begin @(negedge clk); n++; end
    check("tx_frame_started", RsTx, 0);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_midframe_rstx", RsTx, 1);
    check("reset_midframe_tx_ready", tx_ready, 0);
    check("reset_midframe_rx_valid", rx_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    mon_en = 1'b1;
    rx_hold = 1'b0;

    send_frame(8'h41, 1'b1);
    wait_drain();

    send_frame(8'h20, 1'b1);
    send_frame(8'h7B, 1'b1);
    wait_drain();
    check("no_echo_drop", echo_drop, 0);

    rx_hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(8'h30 + i), 1'b1);
      if (i == 15) check("overrun_not_yet", rx_overrun, 0);
    end
    check("overrun_set", rx_overrun, exp_ovr);
    rx_hold = 1'b0;
    wait_drain();
    check("overrun_sticky", rx_overrun, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ovr = 1'b0;
    check("overrun_cleared", rx_overrun, exp_ovr);

    rx_hold = 1'b1;
    repeat (2) @(negedge clk);
    fe0 = fe_cnt;
    send_frame(8'h5A, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    check("frame_err_pulses", fe_cnt - fe0, 1);
    check("frame_err_no_push", rx_valid, 0);

    RsRx = 1'b0;
    repeat (4*DIV) @(negedge clk);
    RsRx = 1'b1;
    repeat (3*BIT_CLKS) @(negedge clk);
    check("glitch_no_frame_err", fe_cnt - fe0, 1);
    check("glitch_no_push", rx_valid, 0);

    // learn the push latency with a non-echoed byte, then hit the echo cycle of 0x61
    fork
      send_frame(8'h20, 1'b1);
      begin
        n = 0;
        while (!rx_valid && n < 3000) begin @(negedge clk); n++; end
        p = cyc;
      end
    join
    s0 = frame_start;
    check("prio_measure", rx_valid, 1);
    rx_hold = 1'b0;
    wait_drain();
    while (((cyc - s0) % DIV) != 0) @(negedge clk);
    tgt = cyc + (p - s0) - 1;
    check_gap = 1'b1;
    fork
      send_frame(8'h61, 1'b1);
      begin
        while (cyc < tgt) @(negedge clk);
        tx_data = 8'h55; tx_valid = 1'b1; #1;
        check("prio_tx_ready", tx_ready, 0);
        host_send(8'h55);
      end
    join
    wait_drain();
    check_gap = 1'b0;

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      if ($urandom_range(0, 1) == 1) host_send(8'($urandom_range(0, 255)));
    end
    wait_drain();
    check("final_echo_drop", echo_drop, 0);
    check("final_rx_overrun", rx_overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
